// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter feeding one UDP header + 64-bit payload stream
// from PORTS requesters into the udp_complete_64 transmit input.
module udp_tx_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = 8,
  parameter int HDR_WIDTH  = 112,
  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS-1:0]            s_hdr_valid,
  output logic [PORTS-1:0]            s_hdr_ready,
  input  logic [PORTS*HDR_WIDTH-1:0]  s_hdr_data,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  output logic [PORTS-1:0]            s_axis_tready,
  input  logic [PORTS-1:0]            s_axis_tlast,
  input  logic [PORTS-1:0]            s_axis_tuser,
  output logic                        m_hdr_valid,
  input  logic                        m_hdr_ready,
  output logic [HDR_WIDTH-1:0]        m_hdr_data,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  output logic [IW-1:0]               grant_index,
  output logic                        busy,
  output logic [31:0]                 frames_sent
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] w_pick;
  logic          w_any;
  logic          w_hdr_hs;
  logic          w_last_hs;
  logic [31:0]   r_frames_sent;
  int            w_idx;

  // Scan from the highest offset down so the nearest requester wins.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    w_idx  = 0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= PORTS) w_idx = w_idx - PORTS;
      if (s_hdr_valid[w_idx]) begin
        w_pick = IW'(w_idx);
        w_any  = 1'b1;
      end
    end
  end

  assign w_hdr_hs  = (r_state == HDR) && s_hdr_valid[r_grant]
                     && m_hdr_ready;
  assign w_last_hs = (r_state == PAYLOAD) && s_axis_tvalid[r_grant]
                     && m_axis_tready && s_axis_tlast[r_grant];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = HDR;
      HDR:     if (w_hdr_hs) w_next = PAYLOAD;
      PAYLOAD: if (w_last_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    s_hdr_ready   = '0;
    s_axis_tready = '0;
    m_hdr_valid   = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    m_hdr_data    = s_hdr_data[r_grant*HDR_WIDTH +: HDR_WIDTH];
    m_axis_tdata  = s_axis_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
    m_axis_tkeep  = s_axis_tkeep[r_grant*KEEP_WIDTH +: KEEP_WIDTH];
    if (r_state == HDR) begin
      m_hdr_valid          = s_hdr_valid[r_grant];
      s_hdr_ready[r_grant] = m_hdr_ready;
    end
    if (r_state == PAYLOAD) begin
      m_axis_tvalid          = s_axis_tvalid[r_grant];
      m_axis_tlast           = s_axis_tlast[r_grant];
      m_axis_tuser           = s_axis_tuser[r_grant];
      s_axis_tready[r_grant] = m_axis_tready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_frames_sent <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) r_grant <= w_pick;
      if (w_last_hs) begin
        r_frames_sent <= r_frames_sent + 32'd1;
        if (r_grant == IW'(PORTS - 1)) r_rr_ptr <= '0;
        else                           r_rr_ptr <= r_grant + IW'(1);
      end
    end
  end

  assign grant_index = r_grant;
  assign busy        = (r_state != IDLE);
  assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: queued frame sources, random throttling,
// transaction-level round-robin model and per-beat checks.
`define CK(t, o, e) check(t, 128'(o), 128'(e))

module tb_udp_tx_arbiter;
  localparam int P  = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int HW = 112;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [P-1:0]    s_hdr_valid;
  logic [P-1:0]    s_hdr_ready;
  logic [P*HW-1:0] s_hdr_data;
  logic [P*DW-1:0] s_axis_tdata;
  logic [P*KW-1:0] s_axis_tkeep;
  logic [P-1:0]    s_axis_tvalid;
  logic [P-1:0]    s_axis_tready;
  logic [P-1:0]    s_axis_tlast;
  logic [P-1:0]    s_axis_tuser;
  logic            m_hdr_valid;
  logic            m_hdr_ready;
  logic [HW-1:0]   m_hdr_data;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic            m_axis_tuser;
  logic [1:0]      grant_index;
  logic            busy;
  logic [31:0]     frames_sent;

  udp_tx_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
    .s_hdr_data(s_hdr_data),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
    .m_hdr_data(m_hdr_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .grant_index(grant_index), .busy(busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [HW-1:0] f_hdr[$];
  int            f_start[$];
  int            f_n[$];
  logic [DW-1:0] b_data[$];
  logic [KW-1:0] b_keep[$];
  logic          b_user[$];
  int            pq[P][$];

  bit          hdr_done[P];
  int          bidx[P];
  int          mon_port = -1;
  int          mon_beat = 0;
  int          rr = 0;
  int          cyc = 0;
  int          last_tl = -1;
  bit          prev_hv = 0;
  bit          chk_bubble = 0;
  int          rdy_mode = 0;
  int          gap_mode = 0;
  int          hold = 0;
  int          gseq[$];
  logic [31:0] exp_frames = '0;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input int p, input int n, input bit spec);
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    f_hdr.push_back(t[HW-1:0]);
    f_start.push_back(b_data.size());
    f_n.push_back(n);
    for (int i = 0; i < n; i++) begin
      b_data.push_back({$urandom, $urandom});
      b_keep.push_back((spec && i == n - 1) ? 8'h0F : 8'hFF);
      b_user.push_back(spec && i == n - 1);
    end
    pq[p].push_back(f_hdr.size() - 1);
  endtask

  function automatic int winner();
    for (int k = 0; k < P; k++)
      if (pq[(rr + k) % P].size() > 0) return (rr + k) % P;
    return -1;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int p = 0; p < P; p++) s += pq[p].size();
    return s;
  endfunction

  task automatic zero_inputs();
    s_hdr_valid = '0; s_hdr_data = '0;
    s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tuser = '0;
    m_hdr_ready = 1'b0; m_axis_tready = 1'b0;
  endtask

  task automatic clear_model();
    for (int p = 0; p < P; p++) begin
      pq[p].delete(); hdr_done[p] = 0; bidx[p] = 0;
    end
    mon_port = -1; mon_beat = 0; rr = 0;
    exp_frames = '0; last_tl = -1; prev_hv = 0;
  endtask

  task automatic step();
    int f, bi, w;
    @(negedge clk);
    cyc++;
    zero_inputs();
    for (int p = 0; p < P; p++) begin
      if (pq[p].size() > 0) begin
        f = pq[p][0];
        s_hdr_data[p*HW +: HW] = f_hdr[f];
        s_hdr_valid[p] = !hdr_done[p];
        if (hdr_done[p]) begin
          bi = f_start[f] + bidx[p];
          s_axis_tvalid[p] = gap_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
          s_axis_tdata[p*DW +: DW] = b_data[bi];
          s_axis_tkeep[p*KW +: KW] = b_keep[bi];
          s_axis_tuser[p] = b_user[bi];
          s_axis_tlast[p] = (bidx[p] == f_n[f] - 1);
        end
      end
    end
    m_hdr_ready   = (hold > 0) ? 1'b0
                  : (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axis_tready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    `CK("one_ready", ($countones(s_hdr_ready)
        + $countones(s_axis_tready)) <= 1, 1);
    if (m_hdr_valid && hold > 0) begin
      w = winner();
      if (w >= 0) `CK("hold_data", m_hdr_data, f_hdr[pq[w][0]]);
      `CK("hold_no_tready", s_axis_tready, 0);
      hold--;
    end
    if (chk_bubble && m_hdr_valid && !prev_hv && last_tl >= 0)
      `CK("bubble", cyc - last_tl, 2);
    prev_hv = m_hdr_valid;
    if (m_hdr_valid && m_hdr_ready) begin
      w = winner();
      `CK("grant", grant_index, w);
      if (w >= 0) begin
        `CK("hdr_data", m_hdr_data, f_hdr[pq[w][0]]);
        mon_port = w; mon_beat = 0; rr = (w + 1) % P;
        gseq.push_back(w);
      end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (mon_port < 0 || pq[mon_port].size() == 0) begin
        `CK("stray_beat", 1, 0);
      end else begin
        f  = pq[mon_port][0];
        bi = f_start[f] + mon_beat;
        `CK("beat_data", m_axis_tdata, b_data[bi]);
        `CK("beat_keep", m_axis_tkeep, b_keep[bi]);
        `CK("beat_user", m_axis_tuser, b_user[bi]);
        `CK("beat_last", m_axis_tlast, mon_beat == f_n[f] - 1);
        mon_beat++;
        if (m_axis_tlast) begin
          exp_frames++; last_tl = cyc;
        end
      end
    end
    for (int p = 0; p < P; p++) begin
      if (s_hdr_valid[p] && s_hdr_ready[p]) hdr_done[p] = 1;
      if (s_axis_tvalid[p] && s_axis_tready[p]) begin
        bidx[p]++;
        if (bidx[p] == f_n[pq[p][0]]) begin
          void'(pq[p].pop_front()); hdr_done[p] = 0; bidx[p] = 0;
        end
      end
    end
  endtask

  task automatic run_all(input int budget);
    int c = 0;
    while (pending() > 0 && c < budget) begin
      step(); c++;
    end
    `CK("drain_timeout", pending(), 0);
    clear_queues_on_timeout();
    step(); step();
    `CK("frames_sent", frames_sent, exp_frames);
  endtask

  task automatic clear_queues_on_timeout();
    if (pending() > 0)
      for (int p = 0; p < P; p++) pq[p].delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    zero_inputs();
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int c;
    zero_inputs();
    clear_model();
    repeat (2) @(negedge clk);
    `CK("rst_grant", grant_index, 0);
    `CK("rst_frames", frames_sent, 0);
    `CK("rst_busy", busy, 0);
    `CK("rst_mvalid", {m_hdr_valid, m_axis_tvalid}, 0);
    `CK("rst_sready", {s_hdr_ready, s_axis_tready}, 0);
    rst_n = 1'b1;

    add_frame(0, 3, 0);
    step();
    `CK("t1_idle_cycle", m_hdr_valid, 0);
    step();
    `CK("t1_hdr_valid", m_hdr_valid, 1);
    `CK("t1_busy", busy, 1);
    run_all(100);
    check("t1_frames", 128'(frames_sent !== 32'd1), 128'(0));

    apply_reset();
    gseq.delete();
    add_frame(0, 2, 0); add_frame(0, 3, 0);
    add_frame(1, 1, 0); add_frame(2, 4, 0); add_frame(3, 2, 0);
    chk_bubble = 1;
    run_all(200);
    chk_bubble = 0;
    check("t2_count", 128'(gseq.size() !== 5), 128'(0));
    for (int i = 0; i < 5 && i < gseq.size(); i++)
      check("t2_order", 128'(gseq[i] !== exp_order[i]), 128'(0));

    hold = 10;
    add_frame(1, 2, 0);
    run_all(200);
    `CK("t3_hold_used", hold, 0);

    rdy_mode = 1; gap_mode = 1;
    add_frame(2, 9, 1);
    run_all(500);

    for (int i = 0; i < 24; i++)
      add_frame($urandom_range(0, P - 1), $urandom_range(1, 6),
                1'($urandom_range(0, 1)));
    run_all(5000);
    rdy_mode = 0; gap_mode = 0;

    add_frame(1, 5, 0);
    c = 0;
    while (!(mon_port == 1 && mon_beat == 2) && c < 50) begin
      step(); c++;
    end
    `CK("t5_reached", c < 50, 1);
    rst_n = 1'b0;
    #1;
    `CK("t5_busy", busy, 0);
    `CK("t5_mvalid", {m_hdr_valid, m_axis_tvalid}, 0);
    `CK("t5_sready", {s_hdr_ready, s_axis_tready}, 0);
    `CK("t5_frames", frames_sent, 0);
    zero_inputs();
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    gseq.delete();
    add_frame(2, 2, 0); add_frame(0, 2, 0);
    run_all(200);
    `CK("t5_first", gseq.size() > 0 ? gseq[0] : -1, 0);

    force dut.r_frames_sent = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_frames_sent;
    @(negedge clk);
    check("t6_preload", 128'(frames_sent !== 32'hFFFF_FFFF), 128'(0));
    exp_frames = 32'hFFFF_FFFF;
    add_frame(3, 1, 0);
    run_all(100);
    check("t6_wrap", 128'(frames_sent !== 32'h0), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
